// File: rtl/koggestone_divider4.sv
// ---------------------------------------------------------------------------
// koggestone_divider4
//
// Sequential unsigned restoring divider. One trial subtraction per cycle,
// MSB first, each trial done by a (WIDTH+1)-bit Kogge-Stone parallel-prefix
// subtractor (a + ~b + 1). Start/done handshake; all outputs registered.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while not busy
//   dividend     WIDTH-bit unsigned dividend, sampled with start
//   divisor      WIDTH-bit unsigned divisor, sampled with start
//   busy         high while an iteration sequence is running
//   done         one-cycle pulse, results valid in that cycle
//   quotient     WIDTH-bit quotient, held until the next accepted start
//   remainder    WIDTH-bit remainder, held until the next accepted start
//   div_by_zero  set with done when the divisor was zero
// ---------------------------------------------------------------------------
module koggestone_divider4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N      = WIDTH + 1;
    localparam int LEVELS = $clog2(N);
    localparam int CW     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] q;
    logic [N-1:0]     r;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             dbz;

    logic [N-1:0]     r_shift;
    logic [N-1:0]     trial;
    logic             no_borrow;
    logic             last_iter;

    // Kogge-Stone subtract: returns {carry_out, a - b}. The +1 of the two's
    // complement enters as carry-in, so carry into bit i is G[i-1:0] | P[i-1:0].
    function automatic logic [N:0] ks_sub(input logic [N-1:0] a,
                                          input logic [N-1:0] b);
        logic [LEVELS:0][N-1:0] g;
        logic [LEVELS:0][N-1:0] p;
        logic [N:0]             c;
        logic [N-1:0]           diff;
        logic [N-1:0]           bn;
        bn   = ~b;
        g[0] = a & bn;
        p[0] = a ^ bn;
        for (int l = 0; l < LEVELS; l++) begin
            g[l+1] = g[l];
            p[l+1] = p[l];
            for (int i = (1 << l); i < N; i++) begin
                g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
            end
        end
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            c[i+1]  = g[LEVELS][i] | (p[LEVELS][i] & c[0]);
            diff[i] = p[0][i] ^ c[i];
        end
        return {c[N], diff};
    endfunction

    // Trial subtraction of the shifted partial remainder.
    always_comb begin
        r_shift            = {r[WIDTH-1:0], q[WIDTH-1]};
        {no_borrow, trial} = ks_sub(r_shift, {1'b0, dvsr});
        last_iter          = (cnt == CW'(WIDTH - 1));
    end

    // The partial remainder MSB is architecturally always 0 when it is
    // observed; it only exists to hold the shifted-in bit during a trial.
    logic unused_r_msb;
    assign unused_r_msb = r[WIDTH];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (divisor != '0) ? RUN : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dvsr  <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            // busy/done come straight from flops so no decode sits on the pins.
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            q    <= dividend;
                            dvsr <= divisor;
                            r    <= '0;
                            cnt  <= '0;
                            dbz  <= 1'b0;
                        end else begin
                            q    <= '1;
                            r    <= {1'b0, dividend};
                            dbz  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r   <= no_borrow ? trial : r_shift;
                    q   <= {q[WIDTH-2:0], no_borrow};
                    cnt <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = q;
    assign remainder   = r[WIDTH-1:0];
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_koggestone_divider4.sv
// ---------------------------------------------------------------------------
// tb_koggestone_divider4
//
// Self-checking bench for koggestone_divider4 (WIDTH=4). Inputs are driven
// and outputs sampled on the falling edge; expected results come from plain
// integer / and % arithmetic.
// ---------------------------------------------------------------------------
module tb_koggestone_divider4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    koggestone_divider4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] model_q(input int a, input int b);
        return (b == 0) ? 4'hF : 4'(a / b);
    endfunction

    function automatic logic [3:0] model_r(input int a, input int b);
        return (b == 0) ? 4'(a) : 4'(a % b);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
                errors++;
                $display("FAIL reset_outputs got b=%b d=%b q=%0d r=%0d z=%b want all 0",
                         busy, done, quotient, remainder, div_by_zero);
            end
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({busy, done} !== {1'(c <= 4), 1'(c == 5)}) begin
                errors++;
                $display("FAIL basic_timing cycle %0d got busy=%b done=%b want busy=%b done=%b",
                         c, busy, done, c <= 4, c == 5);
            end
            if (c >= 5) begin
                checks++;
                if ({quotient, remainder, div_by_zero} !== {4'd4, 4'd1, 1'b0}) begin
                    errors++;
                    $display("FAIL basic_result cycle %0d got q=%0d r=%0d z=%b want q=4 r=1 z=0",
                             c, quotient, remainder, div_by_zero);
                end
            end
        end
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        start = 1'b1; dividend = 4'd5; divisor = 4'd0;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 4'd15, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL divzero_result got b=%b d=%b q=%0d r=%0d z=%b want b=0 d=1 q=15 r=5 z=1",
                     busy, done, quotient, remainder, div_by_zero);
        end
        // Next operation requested in the done cycle.
        start = 1'b1; dividend = 4'd2; divisor = 4'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({busy, done} !== {1'(c <= 4), 1'(c == 5)}) begin
                errors++;
                $display("FAIL b2b_timing cycle %0d got busy=%b done=%b want busy=%b done=%b",
                         c, busy, done, c <= 4, c == 5);
            end
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {4'd0, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_result got q=%0d r=%0d z=%b want q=0 r=2 z=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        int done_at;
        pulses = 0; done_at = -1;
        @(negedge clk);
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                pulses++;
                done_at = c;
                checks++;
                if ({quotient, remainder, div_by_zero} !== {4'd15, 4'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL ignore_result got q=%0d r=%0d z=%b want q=15 r=0 z=0",
                             quotient, remainder, div_by_zero);
                end
            end
            if (c == 2) begin
                start = 1'b1; dividend = 4'd9; divisor = 4'd2;
            end
        end
        checks++;
        if (pulses != 1 || done_at != 5) begin
            errors++;
            $display("FAIL ignore_pulses got %0d pulses at cycle %0d want 1 at cycle 5",
                     pulses, done_at);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_clear got b=%b d=%b q=%0d r=%0d z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_nodone got %0d done pulses want 0", pulses);
        end
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if ({done, quotient, remainder, div_by_zero} !== {1'b1, 4'd4, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL midreset_rerun got d=%b q=%0d r=%0d z=%b want d=1 q=4 r=2 z=0",
                     done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_sweep();
        int cnt;
        int exp_cnt;
        logic got;
        @(negedge clk);
        start = 1'b1; dividend = 4'd0; divisor = 4'd0;
        for (int idx = 0; idx < 256; idx++) begin
            int a;
            int b;
            a = idx / 16;
            b = idx % 16;
            exp_cnt = (b == 0) ? 1 : 5;
            cnt = 0; got = 1'b0;
            while (!got && cnt < 20) begin
                @(negedge clk);
                start = 1'b0;
                cnt++;
                got = done;
            end
            checks++;
            if (cnt != exp_cnt || !got) begin
                errors++;
                $display("FAIL sweep_spacing %0d/%0d got %0d cycles (done=%b) want %0d",
                         a, b, cnt, got, exp_cnt);
            end
            checks++;
            if ({quotient, remainder, div_by_zero} !== {model_q(a, b), model_r(a, b), 1'(b == 0)}) begin
                errors++;
                $display("FAIL sweep_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         a, b, quotient, remainder, div_by_zero,
                         model_q(a, b), model_r(a, b), b == 0);
            end
            if (idx < 255) begin
                start = 1'b1;
                dividend = 4'((idx + 1) / 16);
                divisor  = 4'((idx + 1) % 16);
            end
        end
    endtask

    task automatic test_random();
        int cnt;
        logic got;
        for (int n = 0; n < 60; n++) begin
            int a;
            int b;
            int gap;
            a   = int'($urandom_range(15, 0));
            b   = int'($urandom_range(15, 0));
            gap = int'($urandom_range(3, 0));
            repeat (gap) @(negedge clk);
            @(negedge clk);
            start = 1'b1; dividend = 4'(a); divisor = 4'(b);
            cnt = 0; got = 1'b0;
            while (!got && cnt < 20) begin
                @(negedge clk);
                // Stray start pulses mid-operation must be ignored.
                start = (b != 0 && cnt == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
                dividend = 4'($urandom_range(15, 0));
                divisor  = 4'($urandom_range(15, 1));
                cnt++;
                got = done;
            end
            start = 1'b0;
            checks++;
            if (!got || cnt != ((b == 0) ? 1 : 5)) begin
                errors++;
                $display("FAIL random_latency %0d/%0d got %0d cycles (done=%b)", a, b, cnt, got);
            end
            checks++;
            if ({quotient, remainder, div_by_zero} !== {model_q(a, b), model_r(a, b), 1'(b == 0)}) begin
                errors++;
                $display("FAIL random_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d",
                         a, b, quotient, remainder, div_by_zero, model_q(a, b), model_r(a, b));
            end
            if (b != 0) begin
                checks++;
                if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
                    errors++;
                    $display("FAIL random_invariant %0d/%0d got q=%0d r=%0d", a, b, quotient, remainder);
                end
            end
            // The stray start seen on the done edge may launch a new op; drain it.
            @(negedge clk);
            start = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/koggestone_divider4.md
# koggestone_divider4

Sequential unsigned restoring divider: the inverse arithmetic path to the team's 4-bit Kogge-Stone adder. It computes quotient and remainder with one trial subtraction per cycle, MSB first. Each trial subtraction uses a (WIDTH+1)-bit Kogge-Stone parallel-prefix subtractor, computed as a + ~b + 1. The block sits behind the tile's input pins as a start/done arithmetic core, with results driven onto the tile outputs.

## Interface

Parameters:
- WIDTH, default 4: operand, quotient and remainder width; legal values 2..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only while not busy.
- dividend  input  WIDTH  unsigned dividend; sampled with start.
- divisor  input  WIDTH  unsigned divisor; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; results valid in this cycle.
- quotient  output  WIDTH  unsigned quotient; held until the next accepted start.
- remainder  output  WIDTH  unsigned remainder; held until the next accepted start.
- div_by_zero  output  1  set together with done when divisor was 0; held with the results.

## Operation

- States: IDLE, RUN, DONE. Reset state is IDLE. In reset, busy, done, quotient, remainder and div_by_zero are all 0.
- IDLE or DONE, start=1, divisor≠0:
  - Latch the dividend into the quotient shift register.
  - Latch the divisor.
  - Clear the partial remainder (WIDTH+1 bits).
  - Clear the iteration counter and clear div_by_zero.
  - Go to RUN.
- IDLE or DONE, start=1, divisor=0:
  - Load quotient = all ones and remainder = dividend.
  - Set div_by_zero = 1.
  - Go to DONE. No RUN cycles are executed.
- IDLE or DONE, start=0: stay in the current state. In DONE, return to IDLE.
- RUN, one iteration per cycle:
  - r' = {r[WIDTH-1:0], q[WIDTH-1]}.
  - t = r' − {0, divisor}, computed by the Kogge-Stone subtractor; the carry-out is the no-borrow flag.
  - If there is no borrow: r ← t. Otherwise: r ← r'.
  - q ← {q[WIDTH-2:0], no-borrow}.
  - The counter increments. After the iteration where count = WIDTH−1, go to DONE.
- DONE: done=1 for exactly one cycle. The quotient and remainder registers hold their values.
- remainder output = r[WIDTH-1:0]; r[WIDTH] is always 0 at completion.
- start while in RUN is ignored: operands are not re-sampled and the operation completes unaffected.
- rst asserted in any state, including mid-RUN: at the next edge go to IDLE, clear all outputs, and emit no done pulse.
- Invariant: dividend = quotient·divisor + remainder, with remainder < divisor, whenever div_by_zero=0.

## Timing

- start accepted at edge k (divisor≠0):
  - busy=1 during cycles k+1 … k+WIDTH.
  - RUN iterations occur at edges k+1 … k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH, i.e. cycle k+WIDTH+1, with busy=0.
  - Latency is WIDTH+1 cycles from start to done (5 cycles for WIDTH=4).
- start accepted at edge k with divisor=0:
  - done and div_by_zero are high in cycle k+1.
  - busy never asserts.
- Back-to-back: start high during the done cycle is accepted. The new operation begins, and done deasserts in the next cycle.
- Throughput: one result per WIDTH+1 cycles.
- No combinational path from inputs to outputs. All outputs are registered.
- The subtractor critical path is log2(WIDTH+1) prefix levels and must close in one cycle.

## Test plan

- Reset: hold rst=1 for 2 cycles with start=1 → busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- 13 ÷ 3, start at edge k → busy cycles k+1..k+4; done in cycle k+5 with quotient=4, remainder=1, div_by_zero=0; values held while start=0.
- 5 ÷ 0 → done in the next cycle, busy never high, quotient=15, remainder=5, div_by_zero=1. Follow with 2 ÷ 7 started in the done cycle → quotient=0, remainder=2, div_by_zero=0 five cycles later.
- Start 15 ÷ 1, then pulse start with 9 ÷ 2 at cycle k+2 → ignored; result quotient=15, remainder=0; exactly one done pulse.
- Start 14 ÷ 3, assert rst at cycle k+2 → IDLE next cycle, outputs cleared, no done pulse. Then 14 ÷ 3 completes with quotient=4, remainder=2.
- Exhaustive sweep of all 256 dividend/divisor pairs, each started in the previous done cycle → every result matches the / and % model (divisor 0 → quotient=15, remainder=dividend); done-to-done spacing is exactly 5 cycles, or 1 cycle for divisor 0.
